shift_result_stage: RTL

//  Registered output stage downstream of the 4-bit integer ALU shifter. Captures the

---
 rtl/shift_result_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/shift_result_stage.sv
// Registered output stage for the 4-bit ALU shifter: captures result + flags into a 2-entry skid buffer.
// Optional SHIFT_RESULT_STATS_EN adds saturating transfer/stall counters.
module shift_result_stage #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [WIDTH-1:0]   in_a,
  input  logic               in_dir,
  input  logic [SHAMT_W-1:0] in_shift_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               out_sout
`ifdef SHIFT_RESULT_STATS_EN
  ,
  output logic [15:0]        stat_xfers,
  output logic [15:0]        stat_stalls
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]   m_data, s_data;
  logic               m_zero, s_zero;
  logic               m_sout, s_sout;
  logic               cap_zero, cap_sout;
  logic [SHAMT_W-1:0] left_idx, right_idx;
  logic               accept, drain;
  logic               load_m, load_s, m_from_s;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // WIDTH is a power of two, so WIDTH-amt wraps naturally in SHAMT_W bits.
  assign left_idx  = '0 - in_shift_amt;
  assign right_idx = in_shift_amt - SHAMT_W'(1);
  assign cap_zero  = (in_data == '0);

  always_comb begin
    cap_sout = 1'b0;
    if (in_shift_amt != '0) begin
      cap_sout = in_dir ? in_a[right_idx] : in_a[left_idx];
    end
  end

  always_comb begin
    next_state = state;
    load_m     = 1'b0;
    load_s     = 1'b0;
    m_from_s   = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state = ONE;
          load_m     = 1'b1;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          next_state = TWO;
          load_s     = 1'b1;
        end else if (accept && drain) begin
          load_m     = 1'b1;
        end else if (drain) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          next_state = ONE;
          m_from_s   = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  // Entries only load on an accepted transfer, so idle input junk never reaches them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= '0;
      m_zero <= 1'b0;
      m_sout <= 1'b0;
      s_data <= '0;
      s_zero <= 1'b0;
      s_sout <= 1'b0;
    end else begin
      if (load_m) begin
        m_data <= in_data;
        m_zero <= cap_zero;
        m_sout <= cap_sout;
      end else if (m_from_s) begin
        m_data <= s_data;
        m_zero <= s_zero;
        m_sout <= s_sout;
      end
      if (load_s) begin
        s_data <= in_data;
        s_zero <= cap_zero;
        s_sout <= cap_sout;
      end
    end
  end

  assign out_data = m_data;
  assign out_zero = m_zero;
  assign out_sout = m_sout;

`ifdef SHIFT_RESULT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_xfers  <= '0;
      stat_stalls <= '0;
    end else begin
      if (drain && stat_xfers != 16'hFFFF) stat_xfers <= stat_xfers + 16'd1;
      if (out_valid && !out_ready && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule
